// File: rtl/avmm_block_mover.sv
// Avalon-MM master that moves 1-16 word blocks between the one-cycle-latency data memory
// and the cipher datapath: loads stream out through a small FWFT buffer, stores write straight through.
`timescale 1ns/1ps
module avmm_block_mover #(
    parameter int ADDR_W     = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [4:0]        cmd_len,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    input  logic [31:0]       wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic              avm_debugaccess,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    output logic              avm_clken,
    input  logic [31:0]       avm_readdata
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] ptr_r;
    logic [4:0]        remaining_r;
    logic              inflight_r;
    logic [31:0]       fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0]     wr_idx_r;
    logic [PW-1:0]     rd_idx_r;
    logic [CW-1:0]     fifo_count_r;

    logic              cmd_fire_s;
    logic              issue_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic [4:0]        len_norm_s;
    logic [CW-1:0]     occupancy_s;

    assign avm_debugaccess = avm_write;
    assign avm_byteenable  = 4'hF;
    assign avm_clken       = 1'b1;

    assign rd_valid    = (fifo_count_r != {CW{1'b0}});
    assign rd_data     = fifo_mem_r[rd_idx_r];
    assign pop_s       = rd_valid & rd_ready;
    assign push_s      = inflight_r;
    assign occupancy_s = fifo_count_r + CW'(inflight_r);

    // Fold the out-of-range lengths (0 and 17-31) onto a full 16-word block.
    always_comb begin
        if ((cmd_len == 5'd0) || (cmd_len > 5'd16)) begin
            len_norm_s = 5'd16;
        end else begin
            len_norm_s = cmd_len;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and Avalon strobes.
    always_comb begin
        state_s        = state_r;
        cmd_ready      = 1'b0;
        wr_ready       = 1'b0;
        done           = 1'b0;
        cmd_fire_s     = 1'b0;
        issue_s        = 1'b0;
        accept_s       = 1'b0;
        avm_chipselect = 1'b0;
        avm_write      = 1'b0;
        avm_address    = {ADDR_W{1'b0}};
        avm_writedata  = 32'h0000_0000;
        case (state_r)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cmd_fire_s = 1'b1;
                    state_s    = cmd_op ? STORE : LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if ((remaining_r != 5'd0) && (occupancy_s < DEPTH_C)) begin
                    issue_s        = 1'b1;
                    avm_chipselect = 1'b1;
                    avm_address    = ptr_r;
                end else begin
                    issue_s = 1'b0;
                end
                // Exit on the cycle the last buffered word is consumed so done follows immediately.
                if ((remaining_r == 5'd0) && !inflight_r &&
                    ((fifo_count_r == {CW{1'b0}}) || ((fifo_count_r == CW'(1)) && pop_s))) begin
                    state_s = DONE;
                end else begin
                    state_s = LOAD;
                end
            end
            STORE: begin
                wr_ready = (remaining_r != 5'd0);
                if (wr_valid && (remaining_r != 5'd0)) begin
                    accept_s       = 1'b1;
                    avm_chipselect = 1'b1;
                    avm_write      = 1'b1;
                    avm_address    = ptr_r;
                    avm_writedata  = wr_data;
                end else begin
                    accept_s = 1'b0;
                end
                if (accept_s && (remaining_r == 5'd1)) begin
                    state_s = DONE;
                end else begin
                    state_s = STORE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Address pointer, word countdown and read-return tracking.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_r       <= {ADDR_W{1'b0}};
            remaining_r <= 5'd0;
            inflight_r  <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if (cmd_fire_s) begin
                ptr_r       <= cmd_addr;
                remaining_r <= len_norm_s;
            end else if (issue_s || accept_s) begin
                ptr_r       <= ptr_r + ADDR_W'(1);
                remaining_r <= remaining_r - 5'd1;
            end else begin
                ptr_r       <= ptr_r;
                remaining_r <= remaining_r;
            end
        end
    end

    // Read-return buffer storage; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_idx_r] <= avm_readdata;
        end
    end

    // Read-return buffer pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_idx_r     <= {PW{1'b0}};
            rd_idx_r     <= {PW{1'b0}};
            fifo_count_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_idx_r <= wr_idx_r + PW'(1);
            end
            if (pop_s) begin
                rd_idx_r <= rd_idx_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_count_r <= fifo_count_r + CW'(1);
                2'b01:   fifo_count_r <= fifo_count_r - CW'(1);
                default: fifo_count_r <= fifo_count_r;
            endcase
        end
    end
endmodule
